// File: rtl/regfile_wb_arbiter.sv
// Arbitrates NREQ writeback requesters onto the single register-file write port; 1-cycle latency.
// Backpressure: req_ready drops while rf_hold freezes a pending write; an empty register still accepts.
module regfile_wb_arbiter #(
  parameter int NREQ  = 3,
  parameter bit RR_EN = 1'b1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [5*NREQ-1:0]  req_addr,
  input  logic [32*NREQ-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               rf_hold,
  output logic               rf_we,
  output logic [4:0]         rf_waddr,
  output logic [31:0]        rf_wdata,
  output logic               pend_valid,
  output logic [4:0]         pend_addr
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_t;

  logic            out_valid_q, out_valid_d;
  wb_t             out_q, out_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            active_q, active_d;

  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   idx_v;
  logic [PW:0]     sum;
  logic            found;
  logic [4:0]      win_addr;
  logic [31:0]     win_data;
  logic            can_accept;
  logic            xfer;

  // Search order starts at the pointer (round-robin) or at index 0 (fixed).
  always_comb begin
    gnt      = '0;
    win_idx  = '0;
    idx_v    = '0;
    sum      = '0;
    found    = 1'b0;
    win_addr = '0;
    win_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = RR_EN ? ({1'b0, rr_ptr_q} + (PW+1)'(k)) : (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      idx_v = sum[PW-1:0];
      if (!found && req_valid[idx_v]) begin
        found   = 1'b1;
        win_idx = idx_v;
      end
    end
    gnt[win_idx] = found;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        win_addr = req_addr[5*i +: 5];
        win_data = req_data[32*i +: 32];
      end
    end
  end

  // active_q keeps grants off until the first edge after reset is released.
  assign can_accept = !out_valid_q || !rf_hold;
  assign req_ready  = (can_accept && active_q) ? gnt : '0;
  assign xfer       = |req_ready;

  assign rf_we      = out_valid_q && !rf_hold;
  assign rf_waddr   = out_q.addr;
  assign rf_wdata   = out_q.data;
  assign pend_valid = out_valid_q;
  assign pend_addr  = out_q.addr;

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    rr_ptr_d    = rr_ptr_q;
    active_d    = 1'b1;
    if (xfer) begin
      out_d.addr  = win_addr;
      out_d.data  = win_data;
      out_valid_d = |win_addr;
      rr_ptr_d    = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + 1'b1;
    end else if (!rf_hold) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      rr_ptr_q    <= '0;
      active_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      rr_ptr_q    <= rr_ptr_d;
      active_q    <= active_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: a round-robin and a fixed-priority instance driven from one vector table,
// with a write scoreboard checking every rf_we against the expected grant order.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  vld_rr, vld_fp;
  logic [14:0] addr;
  logic [95:0] data;
  logic        hold;

  logic [2:0]  rdy_rr, rdy_fp;
  logic        we_rr, we_fp, pv_rr, pv_fp;
  logic [4:0]  waddr_rr, waddr_fp, pa_rr, pa_fp;
  logic [31:0] wdata_rr, wdata_fp;

  regfile_wb_arbiter #(.NREQ(3), .RR_EN(1'b1)) u_rr (
    .clk(clk), .resetn(resetn), .req_valid(vld_rr), .req_addr(addr), .req_data(data),
    .req_ready(rdy_rr), .rf_hold(hold), .rf_we(we_rr), .rf_waddr(waddr_rr),
    .rf_wdata(wdata_rr), .pend_valid(pv_rr), .pend_addr(pa_rr));

  regfile_wb_arbiter #(.NREQ(3), .RR_EN(1'b0)) u_fp (
    .clk(clk), .resetn(resetn), .req_valid(vld_fp), .req_addr(addr), .req_data(data),
    .req_ready(rdy_fp), .rf_hold(hold), .rf_we(we_fp), .rf_waddr(waddr_fp),
    .rf_wdata(wdata_fp), .pend_valid(pv_fp), .pend_addr(pa_fp));

  always #5 clk = ~clk;

  typedef struct {
    bit          sel;
    logic [2:0]  vld;
    logic [4:0]  a0, a1, a2;
    logic [31:0] d0, d1, d2;
    logic        hold;
    logic [2:0]  rdy;
    logic        we, pv;
    logic [4:0]  pa;
  } vec_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  vec_t        tbl[$];
  wr_t         sbq[$];
  logic [31:0] rf_mem[32];
  int          n_vec = 0;
  int          n_miss = 0;
  bit          sel = 1'b0;

  logic [2:0]  rdy_m;
  logic        we_m, pv_m;
  logic [4:0]  waddr_m, pa_m;
  logic [31:0] wdata_m;
  assign rdy_m   = sel ? rdy_fp   : rdy_rr;
  assign we_m    = sel ? we_fp    : we_rr;
  assign pv_m    = sel ? pv_fp    : pv_rr;
  assign waddr_m = sel ? waddr_fp : waddr_rr;
  assign pa_m    = sel ? pa_fp    : pa_rr;
  assign wdata_m = sel ? wdata_fp : wdata_rr;

  function automatic vec_t v(input bit s, input logic [2:0] vl,
                             input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                             input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                             input logic h, input logic [2:0] r, input logic w, input logic p,
                             input logic [4:0] pa);
    vec_t t;
    t.sel = s; t.vld = vl; t.a0 = a0; t.a1 = a1; t.a2 = a2;
    t.d0 = d0; t.d1 = d1; t.d2 = d2; t.hold = h;
    t.rdy = r; t.we = w; t.pv = p; t.pa = pa;
    return t;
  endfunction

  function automatic vec_t idle(input bit s, input logic w, input logic p, input logic [4:0] pa);
    return v(s, 3'b000, 0, 0, 0, 0, 0, 0, 1'b0, 3'b000, w, p, pa);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic sb_mon(input string tag);
    wr_t e;
    if (we_m === 1'b1) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL %s write: got addr %0d data %0h, want no write", tag, waddr_m, wdata_m);
      end else begin
        e = sbq.pop_front();
        chk({tag, " waddr"}, 32'(waddr_m), 32'(e.a));
        chk({tag, " wdata"}, wdata_m, e.d);
      end
      rf_mem[waddr_m] = wdata_m;
    end
  endtask

  task automatic apply(input vec_t t, input string tag);
    @(negedge clk);
    sel    = t.sel;
    vld_rr = t.sel ? 3'b000 : t.vld;
    vld_fp = t.sel ? t.vld : 3'b000;
    addr   = {t.a2, t.a1, t.a0};
    data   = {t.d2, t.d1, t.d0};
    hold   = t.hold;
    #1;
    sb_mon(tag);
    chk({tag, " req_ready"},  32'(rdy_m), 32'(t.rdy));
    chk({tag, " rf_we"},      32'(we_m),  32'(t.we));
    chk({tag, " pend_valid"}, 32'(pv_m),  32'(t.pv));
    chk({tag, " pend_addr"},  32'(pa_m),  32'(t.pa));
    if (t.rdy[0] && t.a0 != 5'd0) sbq.push_back(wr_t'{a: t.a0, d: t.d0});
    if (t.rdy[1] && t.a1 != 5'd0) sbq.push_back(wr_t'{a: t.a1, d: t.d1});
    if (t.rdy[2] && t.a2 != 5'd0) sbq.push_back(wr_t'{a: t.a2, d: t.d2});
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = '0;
    resetn = 1'b0;
    sel    = 1'b0;
    vld_rr = 3'b111;
    vld_fp = 3'b111;
    addr   = {5'd3, 5'd2, 5'd1};
    data   = {32'h303, 32'h202, 32'h101};
    hold   = 1'b0;

    // Round-robin fairness, pointer starting at 0.
    for (int r = 0; r < 2; r++) begin
      tbl.push_back(v(0, 3'b111, 1, 2, 3, 'h101, 'h202, 'h303, 0, 3'b001, r != 0, r != 0, (r != 0) ? 5'd3 : 5'd0));
      tbl.push_back(v(0, 3'b111, 1, 2, 3, 'h101, 'h202, 'h303, 0, 3'b010, 1, 1, 1));
      tbl.push_back(v(0, 3'b111, 1, 2, 3, 'h101, 'h202, 'h303, 0, 3'b100, 1, 1, 2));
    end
    tbl.push_back(idle(0, 1, 1, 3));
    tbl.push_back(idle(0, 0, 0, 3));
    // r0 write is consumed silently but still advances the pointer to 2.
    tbl.push_back(v(0, 3'b010, 0, 0, 0, 0, 'hFFFFFFFF, 0, 0, 3'b010, 0, 0, 3));
    tbl.push_back(v(0, 3'b111, 1, 2, 3, 'h101, 'h202, 'h303, 0, 3'b100, 0, 0, 0));
    tbl.push_back(idle(0, 1, 1, 3));
    tbl.push_back(idle(0, 0, 0, 3));
    // Hold with a pending write, then release.
    tbl.push_back(v(0, 3'b001, 7, 0, 0, 'h77, 0, 0, 0, 3'b001, 0, 0, 3));
    for (int h = 0; h < 3; h++)
      tbl.push_back(v(0, 3'b001, 8, 0, 0, 'h88, 0, 0, 1, 3'b000, 0, 1, 7));
    tbl.push_back(v(0, 3'b001, 8, 0, 0, 'h88, 0, 0, 0, 3'b001, 1, 1, 7));
    tbl.push_back(idle(0, 1, 1, 8));
    tbl.push_back(idle(0, 0, 0, 8));
    // Hold while empty: one write accepted, then held.
    tbl.push_back(v(0, 3'b010, 0, 9, 0, 0, 'h99, 0, 1, 3'b010, 0, 0, 8));
    tbl.push_back(v(0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 3'b000, 0, 1, 9));
    tbl.push_back(idle(0, 1, 1, 9));
    tbl.push_back(idle(0, 0, 0, 9));
    // Steer the pointer back to 0, then same-address writes.
    tbl.push_back(v(0, 3'b100, 0, 0, 10, 0, 0, 'h1010, 0, 3'b100, 0, 0, 9));
    tbl.push_back(idle(0, 1, 1, 10));
    tbl.push_back(idle(0, 0, 0, 10));
    tbl.push_back(v(0, 3'b011, 4, 4, 0, 'hA, 'hB, 0, 0, 3'b001, 0, 0, 10));
    tbl.push_back(v(0, 3'b010, 4, 4, 0, 'hA, 'hB, 0, 0, 3'b010, 1, 1, 4));
    tbl.push_back(idle(0, 1, 1, 4));
    tbl.push_back(idle(0, 0, 0, 4));
    // Fixed priority: req0 starves req2 while valid.
    tbl.push_back(v(1, 3'b101, 11, 0, 12, 'h1111, 0, 'hABCD, 0, 3'b001, 0, 0, 0));
    for (int c = 0; c < 3; c++)
      tbl.push_back(v(1, 3'b101, 11, 0, 12, 'h1111, 0, 'hABCD, 0, 3'b001, 1, 1, 11));
    tbl.push_back(v(1, 3'b100, 11, 0, 12, 'h1111, 0, 'hABCD, 0, 3'b100, 1, 1, 11));
    tbl.push_back(idle(1, 1, 1, 12));
    tbl.push_back(idle(1, 0, 0, 12));

    // Reset state with every requester asserting valid.
    #3;
    chk("rst rdy_rr", 32'(rdy_rr), 0);
    chk("rst rdy_fp", 32'(rdy_fp), 0);
    chk("rst we_rr", 32'(we_rr), 0);
    chk("rst we_fp", 32'(we_fp), 0);
    chk("rst waddr", 32'(waddr_rr), 0);
    chk("rst wdata", wdata_rr, 0);
    chk("rst pend_valid", 32'(pv_rr), 0);
    chk("rst pend_addr", 32'(pa_rr), 0);
    @(negedge clk);
    resetn = 1'b1;
    vld_rr = 3'b000;
    vld_fp = 3'b000;
    @(posedge clk);

    foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

    // Asynchronous reset mid-cycle discards a pending write.
    apply(v(0, 3'b001, 13, 0, 0, 'h1313, 0, 0, 0, 3'b001, 0, 0, 4), "mrst accept");
    @(posedge clk);
    #1;
    chk("mrst pre rf_we", 32'(we_m), 1);
    chk("mrst pre pend_valid", 32'(pv_m), 1);
    #1;
    resetn = 1'b0;
    #1;
    chk("mrst rf_we", 32'(we_m), 0);
    chk("mrst pend_valid", 32'(pv_m), 0);
    chk("mrst waddr", 32'(waddr_m), 0);
    chk("mrst wdata", wdata_m, 0);
    chk("mrst req_ready", 32'(rdy_m), 0);
    sbq.delete();
    @(negedge clk);
    resetn = 1'b1;
    vld_rr = 3'b000;
    @(posedge clk);
    apply(v(0, 3'b001, 5, 0, 0, 'h11, 0, 0, 0, 3'b001, 0, 0, 0), "post-rst accept");
    apply(idle(0, 1, 1, 5), "post-rst issue");
    apply(idle(0, 0, 0, 5), "post-rst drain");

    chk("scoreboard drained", 32'(sbq.size()), 0);
    chk("final r4", rf_mem[4], 32'hB);
    chk("final r0 untouched", rf_mem[0], 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
